spram_flush: RTL and testbench

- Copies a block of 32-bit words from iCE40 SPRAM out to external SPI RAM; the write-back counterpart of the SPRAM boot loader.
- Reads SPRAM word by word and bit-reverses each word.
- Issues one 32-bit SPI write per word through an internal spi_ram_controller.
- Triggered by a start pulse from the host logic; reports busy/done.

---
 rtl/spram_flush_pkg.sv | 21 ++
 rtl/spram_flush_spi_ram_controller.sv | 73 +++++++
 rtl/spram_flush.sv | 153 +++++++++++++++
 tb/tb_spram_flush.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_flush_pkg.sv
// Shared types and constants for the SPRAM-to-SPI-RAM flush engine.
package spram_flush_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WREQ,
        WWAIT,
        RREQ,
        RWAIT,
        FINISH
    } state_t;

    // Word address to byte address: 4 bytes per 32-bit word.
    localparam int unsigned BYTE_SHIFT = 2;

    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;

endpackage

// File: rtl/spram_flush_spi_ram_controller.sv
// spi_ram_controller: single 32-bit read/write to SPI RAM (mode 0, clk/2 SCK,
// active-low select). busy rises the cycle after a start is taken.
module spi_ram_controller import spram_flush_pkg::*; #(
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_miso,
    output logic                 spi_select,
    output logic                 spi_clk_out,
    output logic                 spi_mosi,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [31:0]          data_in,
    output logic [31:0]          data_out,
    input  logic                 start_read,
    input  logic                 start_write,
    output logic                 busy
);

    localparam int unsigned HDR_BITS = 8 + ADDR_BITS;
    localparam int unsigned TOT_BITS = HDR_BITS + 32;
    localparam int unsigned CW       = $clog2(TOT_BITS);

    logic [TOT_BITS-1:0] shreg;
    logic [CW-1:0]       bit_cnt;
    logic                active;
    logic                sclk;
    logic                sel;
    logic                is_read;
    logic [31:0]         rd_shift;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            active   <= 1'b0;
            sclk     <= 1'b0;
            sel      <= 1'b1;
            is_read  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rd_shift <= '0;
        end else if (!active) begin
            if (start_write || start_read) begin
                active  <= 1'b1;
                sel     <= 1'b0;
                sclk    <= 1'b0;
                bit_cnt <= '0;
                is_read <= !start_write;
                shreg   <= {start_write ? SPI_CMD_WRITE : SPI_CMD_READ, addr_in,
                            start_write ? data_in : 32'h0};
            end
        end else if (!sclk) begin
            // Rising SCK: RAM samples mosi, we sample miso during the data phase.
            sclk <= 1'b1;
            if (is_read && bit_cnt >= CW'(HDR_BITS))
                rd_shift <= {rd_shift[30:0], spi_miso};
        end else begin
            sclk    <= 1'b0;
            shreg   <= {shreg[TOT_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(TOT_BITS - 1)) begin
                active <= 1'b0;
                sel    <= 1'b1;
            end
        end
    end

    assign spi_select  = sel;
    assign spi_clk_out = sclk;
    assign spi_mosi    = shreg[TOT_BITS-1];
    assign data_out    = rd_shift;
    assign busy        = active;

endmodule

// File: rtl/spram_flush.sv
// Flushes a block of SPRAM words (bit-reversed) out to SPI RAM, one write per word.
// Optional readback verification: define SPRAM_FLUSH_VERIFY_EN.
module spram_flush import spram_flush_pkg::*; #(
    parameter int unsigned           ADDR_BITS = 24,
    parameter int unsigned           SPRAM_AW  = 14,
    parameter logic [ADDR_BITS-1:0]  SPI_BASE  = 24'h000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spi_miso,
    output logic                spi_select,
    output logic                spi_clk_out,
    output logic                spi_mosi,
    input  logic                start,
    input  logic [SPRAM_AW-1:0] first_word,
    input  logic [SPRAM_AW:0]   word_count,
    output logic [SPRAM_AW-1:0] spram_addr,
    input  logic [31:0]         spram_rdat,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam logic [SPRAM_AW:0] REM_ONE = {{SPRAM_AW{1'b0}}, 1'b1};

    state_t                state, state_nx;
    logic [SPRAM_AW-1:0]   addr;
    logic [SPRAM_AW:0]     remaining;
    logic [31:0]           wdata;
    logic [31:0]           rev_data;
    logic                  busy_r;
    logic                  word_end;
    logic                  last_word;
    logic                  ctl_busy;
    logic                  start_write;
    logic                  start_read;
    logic [31:0]           ctl_rdata;
    logic [ADDR_BITS-1:0]  spi_addr;

    for (genvar i = 0; i < 32; i++) begin : g_rev
        assign rev_data[i] = spram_rdat[31-i];
    end

    assign spi_addr  = SPI_BASE + ADDR_BITS'({addr, {BYTE_SHIFT{1'b0}}});
    assign last_word = (remaining == REM_ONE);

    always_comb begin
        state_nx    = state;
        start_write = 1'b0;
        start_read  = 1'b0;
        word_end    = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = (word_count == '0) ? FINISH : FETCH;
            FETCH:  state_nx = LATCH;
            LATCH:  state_nx = WREQ;
            WREQ: begin
                start_write = !ctl_busy;
                if (ctl_busy) state_nx = WWAIT;
            end
            WWAIT: if (!ctl_busy) begin
`ifdef SPRAM_FLUSH_VERIFY_EN
                state_nx = RREQ;
`else
                word_end = 1'b1;
                state_nx = last_word ? FINISH : FETCH;
`endif
            end
`ifdef SPRAM_FLUSH_VERIFY_EN
            RREQ: begin
                start_read = !ctl_busy;
                if (ctl_busy) state_nx = RWAIT;
            end
            RWAIT: if (!ctl_busy) begin
                word_end = 1'b1;
                state_nx = last_word ? FINISH : FETCH;
            end
`endif
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wdata     <= '0;
            busy_r    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    addr      <= first_word;
                    remaining <= word_count;
                    busy_r    <= 1'b1;
                end
                LATCH:   wdata  <= rev_data;
                FINISH:  busy_r <= 1'b0;
                default: ;
            endcase
            // Address advances only once the word (and any readback) is finished.
            if (word_end) begin
                remaining <= remaining - REM_ONE;
                addr      <= addr + 1'b1;
            end
        end
    end

`ifdef SPRAM_FLUSH_VERIFY_EN
    logic error_r;

    always_ff @(posedge clk) begin
        if (rst)
            error_r <= 1'b0;
        else if (state == IDLE && start)
            error_r <= 1'b0;
        else if (state == RWAIT && !ctl_busy && ctl_rdata != wdata)
            error_r <= 1'b1;
    end

    assign error = error_r;
`else
    logic unused_rdata;
    assign unused_rdata = ^ctl_rdata;
    assign error        = 1'b0;
`endif

    assign busy       = busy_r;
    assign spram_addr = addr;

    spi_ram_controller #(
        .ADDR_BITS(ADDR_BITS)
    ) u_spi (
        .clk        (clk),
        .rstn       (!rst),
        .spi_miso   (spi_miso),
        .spi_select (spi_select),
        .spi_clk_out(spi_clk_out),
        .spi_mosi   (spi_mosi),
        .addr_in    (spi_addr),
        .data_in    (wdata),
        .data_out   (ctl_rdata),
        .start_read (start_read),
        .start_write(start_write),
        .busy       (ctl_busy)
    );

endmodule

// File: tb/tb_spram_flush.sv
// Directed bench for spram_flush with an SPRAM model and an SPI RAM model.
module tb_spram_flush;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_miso = 1'b0;
    logic        spi_select, spi_clk_out, spi_mosi;
    logic        start = 1'b0;
    logic [13:0] first_word = '0;
    logic [14:0] word_count = '0;
    logic [13:0] spram_addr;
    logic [31:0] spram_rdat = '0;
    logic        busy, done, error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    spram_flush #(
        .ADDR_BITS(24),
        .SPRAM_AW (14),
        .SPI_BASE (24'h000000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_miso   (spi_miso),
        .spi_select (spi_select),
        .spi_clk_out(spi_clk_out),
        .spi_mosi   (spi_mosi),
        .start      (start),
        .first_word (first_word),
        .word_count (word_count),
        .spram_addr (spram_addr),
        .spram_rdat (spram_rdat),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    logic [31:0] spram [0:16383];
    always @(posedge clk) spram_rdat <= spram[spram_addr];

    // SPI RAM model, sampled mid-cycle.
    logic [23:0]  wr_addr [$];
    logic [31:0]  wr_data [$];
    logic [31:0]  mem_spi [logic [23:0]];
    int unsigned  wr_count = 0, sel_falls = 0, done_count = 0, nbits = 0;
    logic [63:0]  sh = '0;
    logic [31:0]  rd_word = '0;
    logic         in_write = 1'b0, in_read = 1'b0;
    logic         prev_sel = 1'b1, prev_sclk = 1'b0;
    logic         corrupt_en = 1'b0;
    logic [23:0]  corrupt_addr = '0;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
        if (prev_sel === 1'b1 && spi_select === 1'b0) begin
            nbits = 0; sel_falls++; in_write = 1'b0; in_read = 1'b0;
        end
        if (spi_select === 1'b0 && prev_sclk === 1'b0 && spi_clk_out === 1'b1) begin
            sh = {sh[62:0], spi_mosi};
            nbits++;
            if (nbits == 8) begin
                in_write = (sh[7:0] == 8'h02);
                in_read  = (sh[7:0] == 8'h03);
            end
            if (in_read && nbits == 32) begin
                rd_word = mem_spi.exists(sh[23:0]) ? mem_spi[sh[23:0]] : 32'h0;
                if (corrupt_en && sh[23:0] == corrupt_addr) rd_word = rd_word ^ 32'h0000_0020;
            end
            if (in_read && nbits >= 32 && nbits < 64) spi_miso = rd_word[63-nbits];
        end
        if (prev_sel === 1'b0 && spi_select === 1'b1) begin
            if (in_write && nbits == 64) begin
                wr_addr.push_back(sh[55:32]);
                wr_data.push_back(sh[31:0]);
                mem_spi[sh[55:32]] = sh[31:0];
                wr_count++;
            end
            in_write = 1'b0; in_read = 1'b0;
        end
        prev_sel  = spi_select;
        prev_sclk = spi_clk_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [13:0] fw, input logic [14:0] wc);
        first_word = fw; word_count = wc; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while (done !== 1'b1 && n < budget) begin tick(); n++; end
        if (done !== 1'b1) begin
            checks++; errors++;
            $error("FAIL %s: done not seen within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_writes(input string tag, input int unsigned target,
                               input logic need_write, input int unsigned budget);
        int unsigned n = 0;
        while (!(wr_count >= target && (!need_write || in_write)) && n < budget) begin
            tick(); n++;
        end
        if (!(wr_count >= target && (!need_write || in_write))) begin
            checks++; errors++;
            $error("FAIL %s: write %0d not reached within %0d cycles", tag, target, budget);
        end
    endtask

    logic        exp_err;
    int unsigned base, dbase, sbase;

    initial begin
        for (int i = 0; i < 16384; i++) spram[i] = 32'(i);
`ifdef SPRAM_FLUSH_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        // Reset state
        repeat (3) tick();
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_error", {31'b0, error}, 32'h0);
        check("rst_spram_addr", {18'b0, spram_addr}, 32'h0);
        check("rst_select", {31'b0, spi_select}, 32'h1);
        rst = 1'b0;
        tick();

        // Single word at address 0
        spram[0] = 32'h0000_0001;
        pulse_start(14'd0, 15'd1);
        check("t1_busy_after_start", {31'b0, busy}, 32'h1);
        wait_done("t1_done", 2000);
        tick();
        check("t1_busy_low", {31'b0, busy}, 32'h0);
        check("t1_done_low", {31'b0, done}, 32'h0);
        check("t1_wr_count", wr_count, 32'd1);
        check("t1_addr", {8'b0, wr_addr[0]}, 32'h0000_0000);
        check("t1_data", wr_data[0], 32'h8000_0000);
        check("t1_done_count", done_count, 32'd1);

        // Four words wrapping the SPRAM address, with ignored starts
        spram[14'h3FFE] = 32'h0000_00F0;
        spram[14'h3FFF] = 32'h1234_5678;
        spram[0]        = 32'h8000_0001;
        spram[1]        = 32'hFFFF_0000;
        base = wr_count; dbase = done_count;
        pulse_start(14'h3FFE, 15'd4);
        repeat (10) tick();
        pulse_start(14'd5, 15'd2);
        wait_done("t2_done", 4000);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy_after_done_start", {31'b0, busy}, 32'h0);
        repeat (300) tick();
        check("t2_busy_idle", {31'b0, busy}, 32'h0);
        check("t2_wr_count", wr_count - base, 32'd4);
        check("t2_done_count", done_count - dbase, 32'd1);
        check("t2_addr0", {8'b0, wr_addr[base]},   32'h0000_FFF8);
        check("t2_addr1", {8'b0, wr_addr[base+1]}, 32'h0000_FFFC);
        check("t2_addr2", {8'b0, wr_addr[base+2]}, 32'h0000_0000);
        check("t2_addr3", {8'b0, wr_addr[base+3]}, 32'h0000_0004);
        check("t2_data0", wr_data[base],   32'h0F00_0000);
        check("t2_data1", wr_data[base+1], 32'h1E6A_2C48);
        check("t2_data2", wr_data[base+2], 32'h8000_0001);
        check("t2_data3", wr_data[base+3], 32'h0000_FFFF);

        // Zero-length flush
        sbase = sel_falls; dbase = done_count; base = wr_count;
        pulse_start(14'd7, 15'd0);
        check("t3_done", {31'b0, done}, 32'h1);
        check("t3_busy", {31'b0, busy}, 32'h1);
        tick();
        check("t3_done_low", {31'b0, done}, 32'h0);
        check("t3_busy_low", {31'b0, busy}, 32'h0);
        repeat (20) tick();
        check("t3_no_select", sel_falls - sbase, 32'd0);
        check("t3_done_count", done_count - dbase, 32'd1);
        check("t3_no_write", wr_count - base, 32'd0);

        // Reset during the second of three writes
        base = wr_count; dbase = done_count;
        pulse_start(14'd10, 15'd3);
        wait_writes("t4_second_write", base + 1, 1'b1, 3000);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("t4_busy", {31'b0, busy}, 32'h0);
        check("t4_select", {31'b0, spi_select}, 32'h1);
        check("t4_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        repeat (400) tick();
        check("t4_done_count", done_count - dbase, 32'd0);
        check("t4_wr_count", wr_count - base, 32'd1);
        check("t4_busy_idle", {31'b0, busy}, 32'h0);

        // Readback corruption on the second word
        spram[20] = 32'hA5A5_0F0F;
        spram[21] = 32'h0000_0002;
        spram[22] = 32'h0000_0003;
        corrupt_addr = 24'h000054;
        corrupt_en = 1'b1;
        base = wr_count;
        pulse_start(14'd20, 15'd3);
        wait_writes("t5_word2_written", base + 2, 1'b0, 3000);
        check("t5_error_before", {31'b0, error}, 32'h0);
        wait_done("t5_done", 4000);
        check("t5_error_at_done", {31'b0, error}, {31'b0, exp_err});
        tick();
        check("t5_error_sticky", {31'b0, error}, {31'b0, exp_err});
        check("t5_data0", wr_data[base],   32'hF0F0_A5A5);
        check("t5_data1", wr_data[base+1], 32'h4000_0000);
        corrupt_en = 1'b0;
        pulse_start(14'd20, 15'd1);
        check("t5_error_cleared", {31'b0, error}, 32'h0);
        wait_done("t5_done2", 2000);
        check("t5_error_clean", {31'b0, error}, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
